apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
Parametrised APB4 memory-mapped slave that succeeds the fixed 32-bit, 256-word APB memory slave. Data width, depth, base address and wait-state count are generic. Adds byte-lane write strobes (PSTRB), a real PREADY wait-state counter and PSLVERR for misaligned or out-of-range accesses. Sits behind the APB bridge/decoder as a register-file or scratch RAM target.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8, min 8
ADDR_WIDTH, 32, PADDR width in bits
DEPTH, 256, number of DATA_WIDTH-bit words; power of 2
BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_WIDTH/8
WAIT_STATES, 0, PREADY-low cycles inserted per access phase; 0..15

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  slave select
PENABLE  in  1  access-phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  write byte-lane enables
PRDATA  out  DATA_WIDTH  read data; registered
PREADY  out  1  transfer-complete indicator
PSLVERR  out  1  error response; meaningful only while PREADY=1

Behaviour:
- Reset (async, PRESETn=0): FSM=IDLE, wait counter=0, PRDATA=0, latched error=0, so PREADY=0 and PSLVERR=0. Memory contents are not reset and are X until written.
- Derived values: NB=DATA_WIDTH/8, LSB=log2(NB), IW=log2(DEPTH), offset=PADDR-BASE_ADDR.
- Error conditions: PADDR[LSB-1:0]!=0 (misaligned) or PADDR<BASE_ADDR or offset>=DEPTH*NB (out of range).
- FSM states: IDLE, ACCESS.
- IDLE: a setup phase is PSEL=1 and PENABLE=0. On a setup phase:
  - latch index=offset[LSB+IW-1:LSB], PWRITE, PWDATA, PSTRB and the error flag;
  - load wait counter with WAIT_STATES;
  - go to ACCESS.
  - If the access is a read, also load PRDATA at the same edge: mem[index] if no error, else 0.
- ACCESS, PSEL=1 and PENABLE=1:
  - If counter!=0: PREADY=0, decrement counter.
  - If counter==0: PREADY=1 (combinational from state and counter), PSLVERR=latched error.
  - At the edge where PREADY=1: commit a non-error write (lanes with PSTRB[i]=1 written, other lanes unchanged), then return to IDLE.
- Latency: each transfer takes 2+WAIT_STATES cycles. Back-to-back transfers need no idle cycle; a new setup phase is accepted in the IDLE cycle that follows completion.
- Errored write: memory unchanged. Errored read: PRDATA=0. PSLVERR=1 only in the PREADY=1 cycle; 0 at all other times.
- Write with PSTRB=0: no memory change, PSLVERR=0.
- PRDATA holds its last value between reads and is unchanged by writes.
- Changes on PADDR, PWDATA or PSTRB during ACCESS are ignored; values latched at setup are used.
- PSEL=0 during ACCESS (master abort/protocol violation): return to IDLE, no write, PREADY=0.
- PENABLE=1 with PSEL=1 while in IDLE (no setup seen): ignored, PREADY stays 0.
- Reset asserted mid-access: transfer is dropped with no write committed; outputs go to reset values immediately.
- Simultaneous completion of a write and a setup phase for a read of the same address: impossible on legal APB, since setup follows completion. The read therefore sees the new data.

Test Plan:
1. Defaults. Write 0xDEADBEEF to 0x10 with PSTRB=4'hF, then read 0x10 -> PREADY high in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0. Each transfer takes 2 cycles.
2. Byte strobes. Write 0xFFFFFFFF to 0x20, then write 0x11223344 to 0x20 with PSTRB=4'b0101, then read 0x20 -> 0xFF22FF44.
3. WAIT_STATES=3. Read and write accesses -> PREADY low for exactly 3 ACCESS cycles, high on the 4th. Write visible only after the completion edge.
4. Errors (defaults). Read 0x402 (misaligned) -> PRDATA=0, PSLVERR=1. Write 0x400 (out of range, DEPTH=256) -> PSLVERR=1 and a sweep read of all words shows no change. BASE_ADDR=0x1000: access to 0x0FFC -> PSLVERR=1.
5. Abort and reset. Drop PSEL mid-ACCESS on a write with WAIT_STATES=2 -> no write, FSM back to IDLE. Pulse PRESETn low during ACCESS -> PRDATA=0, PREADY=0, PSLVERR=0 asynchronously and the write is not committed.
6. Parameter sweep at DATA_WIDTH=64, DEPTH=16. Back-to-back writes then reads across all 16 words -> data matches, boundary word 15 succeeds, word 16 errors.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB4 scratch-RAM / register-file slave with byte strobes, programmable wait states
// and PSLVERR on misaligned or out-of-window accesses.
module apb_mem_slave #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   SPAN       = (ADDR_WIDTH+1)'(DEPTH * NB);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic [IW-1:0]         idx;
        logic                  wr;
        logic                  err;
        logic [NB-1:0]         strb;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    req_t                req_q;
    logic                setup, done;
    logic [ADDR_WIDTH:0] offset;
    logic                addr_err;
    logic [IW-1:0]       idx;

    logic [NB-1:0][7:0]  mem [DEPTH];

    // Offset is one bit wider so the window check cannot wrap.
    assign offset   = {1'b0, PADDR} - {1'b0, BASE_ADDR};
    assign addr_err = ((PADDR & ALIGN_MASK) != '0) || (PADDR < BASE_ADDR) || (offset >= SPAN);
    assign idx      = offset[LSB+IW-1:LSB];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        setup   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup   = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign PREADY  = done;
    assign PSLVERR = done && req_q.err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            PRDATA  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup) begin
                req_q <= '{idx: idx, wr: PWRITE, err: addr_err, strb: PSTRB, wdata: PWDATA};
                if (!PWRITE)
                    PRDATA <= addr_err ? '0 : mem[idx];
            end
        end
    end

    // Storage is deliberately unreset; commit is gated by the reset-cleared FSM.
    always_ff @(posedge PCLK) begin
        if (done && req_q.wr && !req_q.err) begin
            for (int i = 0; i < NB; i++)
                if (req_q.strb[i])
                    mem[req_q.idx][i] <= req_q.wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave across four parameter sets sharing one APB bus.
module tb_apb_mem_slave;
    logic        clk, rstn;
    logic [3:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic [31:0] prd0, prd1, prd2;
    logic [63:0] prd3;
    logic [3:0]  rdy, serr;

    int          ncmp = 0, nerr = 0;
    logic [31:0] m [256];
    logic [63:0] rd;
    logic        er;
    int          cyc;

    apb_mem_slave u0 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
        .PRDATA(prd0), .PREADY(rdy[0]), .PSLVERR(serr[0]));

    apb_mem_slave #(.WAIT_STATES(3)) u1 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
        .PRDATA(prd1), .PREADY(rdy[1]), .PSLVERR(serr[1]));

    apb_mem_slave #(.WAIT_STATES(2), .BASE_ADDR(32'h1000)) u2 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]),
        .PRDATA(prd2), .PREADY(rdy[2]), .PSLVERR(serr[2]));

    apb_mem_slave #(.DATA_WIDTH(64), .DEPTH(16)) u3 (
        .PCLK(clk), .PRESETn(rstn), .PSEL(psel[3]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prd3), .PREADY(rdy[3]), .PSLVERR(serr[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] prd(input int s);
        case (s)
            0:       return {32'b0, prd0};
            1:       return {32'b0, prd1};
            2:       return {32'b0, prd2};
            default: return prd3;
        endcase
    endfunction

    // Entered #1 after a rising edge; returns #1 after the completion edge so that
    // a following call issues its setup phase back-to-back.
    task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] st, output logic [63:0] r, output logic e, output int c);
        logic ok;
        psel    = 4'b0;
        psel[s] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = st;
        @(posedge clk); #1;
        penable = 1'b1;
        c  = 2;
        e  = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdy[s]) begin
                ok = 1'b1;
                e  = serr[s];
                break;
            end
            c++;
            // The slave must use the values latched at setup.
            paddr  = ~a;
            pwdata = ~d;
            pstrb  = ~st;
        end
        @(posedge clk); #1;
        if (!ok) chk("pready_timeout", 64'(ok), 64'd1);
        r       = prd(s);
        psel    = 4'b0;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; psel = 4'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        @(negedge clk);
        chk("rst_pready", {60'b0, rdy}, 64'd0);
        chk("rst_pslverr", {60'b0, serr}, 64'd0);
        chk("rst_prdata0", prd(0), 64'd0);
        chk("rst_prdata3", prd(3), 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Fill u0 so later sweeps compare against known contents.
        for (int i = 0; i < 256; i++) begin
            m[i] = 32'hC0DE0000 | 32'(i);
            xfer(0, 1'b1, 32'(i * 4), 64'(m[i]), 8'hF, rd, er, cyc);
        end

        // Basic write/read, 2-cycle transfers.
        xfer(0, 1'b1, 32'h10, 64'hDEADBEEF, 8'hF, rd, er, cyc);
        m[4] = 32'hDEADBEEF;
        chk("t1_wr_cycles", 64'(cyc), 64'd2);
        chk("t1_wr_err", 64'(er), 64'd0);
        xfer(0, 1'b0, 32'h10, 64'h0, 8'h0, rd, er, cyc);
        chk("t1_rd_data", rd, 64'hDEADBEEF);
        chk("t1_rd_err", 64'(er), 64'd0);
        chk("t1_rd_cycles", 64'(cyc), 64'd2);

        // Byte strobes; zero strobe is a no-op without error.
        xfer(0, 1'b1, 32'h20, 64'hFFFFFFFF, 8'hF, rd, er, cyc);
        xfer(0, 1'b1, 32'h20, 64'h11223344, 8'h5, rd, er, cyc);
        xfer(0, 1'b1, 32'h20, 64'h00000000, 8'h0, rd, er, cyc);
        chk("t2_zero_strb_err", 64'(er), 64'd0);
        m[8] = 32'hFF22FF44;
        xfer(0, 1'b0, 32'h20, 64'h0, 8'h0, rd, er, cyc);
        chk("t2_strb_data", rd, 64'hFF22FF44);
        xfer(0, 1'b1, 32'h24, 64'h55555555, 8'hF, rd, er, cyc);
        m[9] = 32'h55555555;
        chk("t2_prdata_hold", rd, 64'hFF22FF44);

        // PENABLE without a setup phase is ignored.
        psel[0] = 1'b1; penable = 1'b1;
        @(negedge clk);
        chk("idle_penable", 64'(rdy[0]), 64'd0);
        @(posedge clk); #1;
        psel = 4'b0; penable = 1'b0;

        // Error responses on u0.
        xfer(0, 1'b0, 32'h402, 64'h0, 8'h0, rd, er, cyc);
        chk("t4_misalign_err", 64'(er), 64'd1);
        chk("t4_misalign_data", rd, 64'd0);
        xfer(0, 1'b0, 32'h3FC, 64'h0, 8'h0, rd, er, cyc);
        chk("t4_last_word_err", 64'(er), 64'd0);
        chk("t4_last_word_data", rd, 64'(m[255]));
        xfer(0, 1'b1, 32'h400, 64'hBAADBAAD, 8'hF, rd, er, cyc);
        chk("t4_oor_wr_err", 64'(er), 64'd1);
        xfer(0, 1'b1, 32'h11, 64'hBAADBAAD, 8'hF, rd, er, cyc);
        chk("t4_mis_wr_err", 64'(er), 64'd1);
        @(negedge clk);
        chk("t4_pslverr_idle", 64'(serr[0]), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            xfer(0, 1'b0, 32'(i * 4), 64'h0, 8'h0, rd, er, cyc);
            chk($sformatf("t4_sweep_%0d", i), rd, 64'(m[i]));
        end

        // Wait states: 3 low access cycles, ready on the 4th.
        xfer(1, 1'b1, 32'h8, 64'hCAFEF00D, 8'hF, rd, er, cyc);
        chk("t3_wr_cycles", 64'(cyc), 64'd5);
        chk("t3_wr_err", 64'(er), 64'd0);
        xfer(1, 1'b0, 32'h8, 64'h0, 8'h0, rd, er, cyc);
        chk("t3_rd_cycles", 64'(cyc), 64'd5);
        chk("t3_rd_data", rd, 64'hCAFEF00D);

        // Offset base window and master abort on u2.
        xfer(2, 1'b1, 32'h1000, 64'h600DF00D, 8'hF, rd, er, cyc);
        chk("t5_base_wr_cycles", 64'(cyc), 64'd4);
        xfer(2, 1'b0, 32'h0FFC, 64'h0, 8'h0, rd, er, cyc);
        chk("t5_below_base_err", 64'(er), 64'd1);
        chk("t5_below_base_data", rd, 64'd0);
        xfer(2, 1'b0, 32'h1400, 64'h0, 8'h0, rd, er, cyc);
        chk("t5_above_err", 64'(er), 64'd1);
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1000;
        pwdata = 64'hBAD0BAD0; pstrb = 8'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("t5_abort_wait", 64'(rdy[2]), 64'd0);
        @(posedge clk); #1;
        psel = 4'b0; penable = 1'b0;
        @(negedge clk);
        chk("t5_abort_pready", 64'(rdy[2]), 64'd0);
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'h1000, 64'h0, 8'h0, rd, er, cyc);
        chk("t5_abort_data", rd, 64'h600DF00D);
        chk("t5_abort_cycles", 64'(cyc), 64'd4);

        // Reset mid-access drops the write and clears outputs immediately.
        xfer(0, 1'b0, 32'h10, 64'h0, 8'h0, rd, er, cyc);
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 64'h12345678; pstrb = 8'hF;
        @(posedge clk); #1 penable = 1'b1;
        #1 chk("t5_pre_rst_ready", 64'(rdy[0]), 64'd1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_prdata", prd(0), 64'd0);
        chk("t5_rst_pready", 64'(rdy[0]), 64'd0);
        chk("t5_rst_pslverr", 64'(serr[0]), 64'd0);
        @(posedge clk); #1;
        psel = 4'b0; penable = 1'b0; rstn = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h10, 64'h0, 8'h0, rd, er, cyc);
        chk("t5_rst_no_commit", rd, 64'hDEADBEEF);

        // 64-bit, 16-word instance.
        for (int i = 0; i < 16; i++)
            xfer(3, 1'b1, 32'(i * 8), 64'h0123456789AB0000 | 64'(i), 8'hFF, rd, er, cyc);
        for (int i = 0; i < 16; i++) begin
            xfer(3, 1'b0, 32'(i * 8), 64'h0, 8'h0, rd, er, cyc);
            chk($sformatf("t6_rd_%0d", i), rd, 64'h0123456789AB0000 | 64'(i));
            if (i == 15) chk("t6_word15_err", 64'(er), 64'd0);
        end
        xfer(3, 1'b0, 32'h80, 64'h0, 8'h0, rd, er, cyc);
        chk("t6_word16_err", 64'(er), 64'd1);
        chk("t6_word16_data", rd, 64'd0);
        xfer(3, 1'b0, 32'h04, 64'h0, 8'h0, rd, er, cyc);
        chk("t6_misalign_err", 64'(er), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
